ro_freq_compare: RTL and testbench

//  Downstream consumer of the ring-oscillator bank. Per request, enables two ROs selected by the challenge,

---
 rtl/ro_puf_pkg.sv | 22 ++
 rtl/ro_freq_compare_if.sv | 35 +++
 rtl/ro_edge_counter.sv | 50 +++++
 rtl/ro_freq_compare.sv | 155 +++++++++++++++
 tb/tb_ro_freq_compare.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
`default_nettype none
// ============================================================================
// Module : ro_puf_pkg
// Brief  : Shared FSM state encoding and bank-size defaults for the RO PUF.
// Rev    : 1.0  initial release
// ============================================================================
package ro_puf_pkg;

   localparam int NUM_RO_DEF = 16;
   localparam int SEL_W_DEF  = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_MEASURE = 3'd3,
      ST_COMPARE = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ro_freq_compare_if.sv
`default_nettype none
// ============================================================================
// Module : ro_freq_compare_if
// Brief  : Request, RO-bank and result signals of the frequency comparator.
// Rev    : 1.0  initial release
// ============================================================================
interface ro_freq_compare_if #(
   parameter int NUM_RO = 16,
   parameter int SEL_W  = 4,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [SEL_W-1:0]  challenge_a;
   logic [SEL_W-1:0]  challenge_b;
   logic [NUM_RO-1:0] ro_out;
   logic [NUM_RO-1:0] ro_enable;
   logic              ro_rst;
   logic              busy;
   logic              done;
   logic              response;
   logic              tie;
   logic [CNT_W-1:0]  count_a;
   logic [CNT_W-1:0]  count_b;

   modport master (
      output start, challenge_a, challenge_b, ro_out,
      input  ro_enable, ro_rst, busy, done, response, tie, count_a, count_b
   );

   modport slave (
      input  start, challenge_a, challenge_b, ro_out,
      output ro_enable, ro_rst, busy, done, response, tie, count_a, count_b
   );
endinterface
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ============================================================================
// Module : ro_edge_counter
// Brief  : Synchronizer chain, rising-edge detect and saturating edge counter.
// Rev    : 1.0  initial release
// ============================================================================
module ro_edge_counter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_clear,
   input  wire logic             i_count_en,
   input  wire logic             i_ro,
   output logic      [CNT_W-1:0] o_count
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [CNT_W-1:0]       r_count;
   logic                   w_sync_out;
   logic                   w_rise;

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign w_rise     = w_sync_out & ~r_prev;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= (r_sync << 1) | SYNC_STAGES'(i_ro);
         r_prev <= w_sync_out;
      end
   end

   // Saturate at all-ones so a fast RO can never wrap below a slower one.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_count_en && w_rise && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ro_freq_compare.sv
`default_nettype none
// ============================================================================
// Module : ro_freq_compare
// Brief  : Enables a challenge-selected RO pair, counts edges over a window, compares.
// Rev    : 1.0  initial release
// ============================================================================
module ro_freq_compare
   import ro_puf_pkg::*;
#(
   parameter int NUM_RO        = NUM_RO_DEF,
   parameter int SEL_W         = SEL_W_DEF,
   parameter int CNT_W         = 16,
   parameter int WIN_CYCLES    = 1024,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input wire logic         clk,
   input wire logic         rst,
   ro_freq_compare_if.slave bus
);

   localparam int c_tmr_max = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_tmr_w-1:0] r_tmr;
   logic               w_tmr_load;
   logic [c_tmr_w-1:0] w_tmr_val;
   logic [SEL_W-1:0]   r_chal_a;
   logic [SEL_W-1:0]   r_chal_b;
   logic [NUM_RO-1:0]  w_pair_mask;
   logic               w_ro_a;
   logic               w_ro_b;
   logic [CNT_W-1:0]   w_cnt_a;
   logic [CNT_W-1:0]   w_cnt_b;
   logic [CNT_W-1:0]   r_count_a;
   logic [CNT_W-1:0]   r_count_b;
   logic               r_response;
   logic               r_tie;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_load  = 1'b0;
      w_tmr_val   = '0;
      case (r_state)
         ST_IDLE:    if (bus.start) w_state_nxt = ST_CLEAR;
         ST_CLEAR: begin
            w_state_nxt = ST_SETTLE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_tmr_w'(SETTLE_CYCLES - 1);
         end
         ST_SETTLE: begin
            if (r_tmr == '0) begin
               w_state_nxt = ST_MEASURE;
               w_tmr_load  = 1'b1;
               w_tmr_val   = c_tmr_w'(WIN_CYCLES - 1);
            end
         end
         ST_MEASURE: if (r_tmr == '0) w_state_nxt = ST_COMPARE;
         ST_COMPARE: w_state_nxt = ST_DONE;
         ST_DONE:    w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // One down-counter serves both the settle and the measurement windows.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmr <= '0;
      end else if (w_tmr_load) begin
         r_tmr <= w_tmr_val;
      end else if (r_tmr != '0) begin
         r_tmr <= r_tmr - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_chal_a <= '0;
         r_chal_b <= '0;
      end else if ((r_state == ST_IDLE) && bus.start) begin
         r_chal_a <= bus.challenge_a;
         r_chal_b <= bus.challenge_b;
      end
   end

   // Indices with no matching RO leave both the enable and the tap at 0.
   always_comb begin
      w_pair_mask = '0;
      w_ro_a      = 1'b0;
      w_ro_b      = 1'b0;
      for (int i = 0; i < NUM_RO; i++) begin
         if (r_chal_a == SEL_W'(i)) begin
            w_pair_mask[i] = 1'b1;
            w_ro_a         = bus.ro_out[i];
         end
         if (r_chal_b == SEL_W'(i)) begin
            w_pair_mask[i] = 1'b1;
            w_ro_b         = bus.ro_out[i];
         end
      end
   end

   ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (r_state == ST_CLEAR),
      .i_count_en (r_state == ST_MEASURE),
      .i_ro       (w_ro_a),
      .o_count    (w_cnt_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (r_state == ST_CLEAR),
      .i_count_en (r_state == ST_MEASURE),
      .i_ro       (w_ro_b),
      .o_count    (w_cnt_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count_a  <= '0;
         r_count_b  <= '0;
         r_response <= 1'b0;
         r_tie      <= 1'b0;
      end else if (r_state == ST_COMPARE) begin
         r_count_a  <= w_cnt_a;
         r_count_b  <= w_cnt_b;
         r_response <= (w_cnt_a > w_cnt_b);
         r_tie      <= (w_cnt_a == w_cnt_b);
      end
   end

   assign bus.ro_enable = ((r_state == ST_SETTLE) || (r_state == ST_MEASURE)) ? w_pair_mask : '0;
   assign bus.ro_rst    = (r_state == ST_CLEAR);
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.response  = r_response;
   assign bus.tie       = r_tie;
   assign bus.count_a   = r_count_a;
   assign bus.count_b   = r_count_b;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_compare.sv
`default_nettype none
// ============================================================================
// Module : tb_ro_freq_compare
// Brief  : Scoreboard bench; two DUTs (CNT_W 16 and 4) share one ideal RO bank.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ro_freq_compare;

   localparam int c_win    = 100;
   localparam int c_settle = 4;

   typedef struct {
      int          done_cyc;
      logic [15:0] ca;
      logic [15:0] cb;
      logic        resp;
      logic        tie;
      logic [3:0]  ca4;
      logic [3:0]  cb4;
      logic        resp4;
      logic        tie4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];
   int          period[16];
   int          m_start = -1000000;
   int          en_from = -1, en_to = -1, busy_from = -1, busy_to = -1, clr_cyc = -1;
   logic [15:0] en_mask = '0;

   ro_freq_compare_if #(.NUM_RO(16), .SEL_W(4), .CNT_W(16)) bus16 ();
   ro_freq_compare_if #(.NUM_RO(16), .SEL_W(4), .CNT_W(4))  bus4 ();

   ro_freq_compare #(.NUM_RO(16), .SEL_W(4), .CNT_W(16), .WIN_CYCLES(c_win),
                     .SETTLE_CYCLES(c_settle), .SYNC_STAGES(2)) u_dut16 (
      .clk (clk), .rst (rst), .bus (bus16));

   ro_freq_compare #(.NUM_RO(16), .SEL_W(4), .CNT_W(4), .WIN_CYCLES(c_win),
                     .SETTLE_CYCLES(c_settle), .SYNC_STAGES(2)) u_dut4 (
      .clk (clk), .rst (rst), .bus (bus4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
      end
   endtask

   // Ideal RO bank: square waves that only run while enabled, phase 0 at MEASURE entry.
   always begin
      logic [15:0] v16, v4;
      @(posedge clk);
      #1;
      v16 = '0;
      v4  = '0;
      for (int i = 0; i < 16; i++) begin
         int t;
         logic w;
         t = cyc - m_start;
         w = (t >= 0) && (period[i] > 0) && ((t % period[i]) < (period[i] / 2));
         v16[i] = w && bus16.ro_enable[i];
         v4[i]  = w && bus4.ro_enable[i];
      end
      bus16.ro_out = v16;
      bus4.ro_out  = v4;
   end

   always @(negedge clk) begin
      if (!rst) begin
         logic [15:0] exp_en;
         exp_en = (cyc >= en_from && cyc <= en_to) ? en_mask : 16'h0;
         chk("ro_enable16", 32'(bus16.ro_enable), 32'(exp_en));
         chk("ro_enable4",  32'(bus4.ro_enable),  32'(exp_en));
         chk("busy", 32'(bus16.busy), 32'(cyc >= busy_from && cyc <= busy_to));
         chk("ro_rst", 32'(bus16.ro_rst), 32'(cyc == clr_cyc));
         chk("done4_eq", 32'(bus4.done), 32'(bus16.done));
         if (bus16.done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(bus16.done), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
               chk("count_a",    32'(bus16.count_a),  32'(e.ca));
               chk("count_b",    32'(bus16.count_b),  32'(e.cb));
               chk("response",   32'(bus16.response), 32'(e.resp));
               chk("tie",        32'(bus16.tie),      32'(e.tie));
               chk("count_a4",   32'(bus4.count_a),   32'(e.ca4));
               chk("count_b4",   32'(bus4.count_b),   32'(e.cb4));
               chk("response4",  32'(bus4.response),  32'(e.resp4));
               chk("tie4",       32'(bus4.tie),       32'(e.tie4));
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
            chk("done_timeout", 32'(bus16.done), 32'd1);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic set_req(input int a, input int b, input logic st);
      bus16.start = st;  bus4.start = st;
      bus16.challenge_a = 4'(a);  bus4.challenge_a = 4'(a);
      bus16.challenge_b = 4'(b);  bus4.challenge_b = 4'(b);
   endtask

   task automatic issue(input int a, input int b,
                        input int ca, input int cb, input logic r, input logic t,
                        input int ca4, input int cb4, input logic r4, input logic t4);
      int   c0;
      exp_t e;
      @(posedge clk);
      #1;
      set_req(a, b, 1'b1);
      c0        = cyc;
      m_start   = c0 + c_settle + 2;
      clr_cyc   = c0 + 1;
      en_from   = c0 + 2;
      en_to     = c0 + c_settle + c_win + 1;
      en_mask   = (16'd1 << a) | (16'd1 << b);
      busy_from = c0 + 1;
      busy_to   = c0 + c_settle + c_win + 3;
      e.done_cyc = c0 + c_settle + c_win + 3;
      e.ca = 16'(ca);  e.cb = 16'(cb);  e.resp = r;   e.tie = t;
      e.ca4 = 4'(ca4); e.cb4 = 4'(cb4); e.resp4 = r4; e.tie4 = t4;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      set_req(a, b, 1'b0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) period[i] = 0;
      bus16.ro_out = '0;
      bus4.ro_out  = '0;
      set_req(0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_count_a",  32'(bus16.count_a),  32'd0);
      chk("rst_count_b",  32'(bus16.count_b),  32'd0);
      chk("rst_response", 32'(bus16.response), 32'd0);
      chk("rst_tie",      32'(bus16.tie),      32'd0);
      chk("rst_done",     32'(bus16.done),     32'd0);

      period[0] = 10; period[1] = 20;
      issue(0, 1, 10, 5, 1'b1, 1'b0, 10, 5, 1'b1, 1'b0);
      wait_drain();

      period[2] = 20; period[7] = 10;
      issue(2, 7, 5, 10, 1'b0, 1'b0, 5, 10, 1'b0, 1'b0);
      wait_drain();

      period[3] = 10;
      issue(3, 3, 10, 10, 1'b0, 1'b1, 10, 10, 1'b0, 1'b1);
      wait_drain();

      // 49 and 25 edges: the 4-bit instance saturates both sides and ties.
      period[4] = 2; period[8] = 4;
      issue(4, 8, 49, 25, 1'b1, 1'b0, 15, 15, 1'b0, 1'b1);
      wait_drain();

      period[5] = 2; period[6] = 2;
      issue(0, 1, 10, 5, 1'b1, 1'b0, 10, 5, 1'b1, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      set_req(5, 6, 1'b1);
      @(posedge clk);
      #1;
      set_req(5, 6, 1'b0);
      wait_drain();

      // Reset mid-MEASURE: the pending result is dropped and no done may follow.
      issue(2, 7, 5, 10, 1'b0, 1'b0, 5, 10, 1'b0, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      en_to   = cyc;
      busy_to = cyc;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy",     32'(bus16.busy),      32'd0);
      chk("midrst_enable",   32'(bus16.ro_enable), 32'd0);
      chk("midrst_count_a",  32'(bus16.count_a),   32'd0);
      chk("midrst_count_b",  32'(bus16.count_b),   32'd0);
      chk("midrst_response", 32'(bus16.response),  32'd0);
      repeat (120) @(posedge clk);

      issue(0, 1, 10, 5, 1'b1, 1'b0, 10, 5, 1'b1, 1'b0);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, actual running required finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
